// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator MMIO front end:
// address map, CTRL/STATUS bit positions and the sequencing FSM states.
package fact_pkg;

  localparam logic [1:0] FACT_A_N      = 2'd0;
  localparam logic [1:0] FACT_A_CTRL   = 2'd1;
  localparam logic [1:0] FACT_A_STATUS = 2'd2;
  localparam logic [1:0] FACT_A_RESULT = 2'd3;

  localparam int unsigned CTRL_GO_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CTRL_IE_BIT  = 2;

  localparam int unsigned STAT_DONE_BIT = 0;
  localparam int unsigned STAT_ERR_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } fact_mmio_state_t;

endpackage

// File: rtl/fact_mmio.sv
// Register front end for the factorial accelerator: operand latch, start pulse,
// result/error capture. Define FACT_IRQ_EN to add the IE bit and the irq output.
module fact_mmio
  import fact_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_W    = 4,
  parameter int unsigned RES_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [1:0]        A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic [N_W-1:0]    n_out,
  output logic              go_out,
  input  logic              done_in,
  input  logic              error_in,
  input  logic [RES_W-1:0]  result_in
`ifdef FACT_IRQ_EN
  ,
  output logic              irq
`endif
);

  fact_mmio_state_t state_q, state_d;

  logic [N_W-1:0]   n_q;
  logic [RES_W-1:0] result_q;
  logic             done_q;
  logic             err_q;
  logic             go_q;
  logic             ie_rd;

  logic idle;
  logic wr_n;
  logic wr_ctrl;
  logic go_req;
  logic clr_req;

  // Only the low WD bits are architected; the rest are don't-care on writes.
  logic unused_wd;
  assign unused_wd = ^WD;

  assign idle    = (state_q == IDLE);
  assign wr_n    = WE && (A == FACT_A_N) && idle;
  assign wr_ctrl = WE && (A == FACT_A_CTRL);
  assign go_req  = wr_ctrl && WD[CTRL_GO_BIT] && idle;
  assign clr_req = wr_ctrl && WD[CTRL_CLR_BIT] && !WD[CTRL_GO_BIT] && idle;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_req) state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (done_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // GO clears the previous outcome; completion/error only count while BUSY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= (state_d == START);
      if (wr_n) n_q <= WD[N_W-1:0];
      if (go_req) begin
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        result_q <= '0;
      end else if (clr_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else if (state_q == BUSY) begin
        if (error_in) err_q <= 1'b1;
        if (done_in) begin
          result_q <= result_in;
          done_q   <= 1'b1;
        end
      end
    end
  end

`ifdef FACT_IRQ_EN
  logic ie_q;
  logic irq_q;

  // irq follows DONE&IE one cycle late, but drops on the edge that clears either.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= WD[CTRL_IE_BIT];
      irq_q <= done_q && ie_q &&
               !(go_req || clr_req || (wr_ctrl && !WD[CTRL_IE_BIT]));
    end
  end

  assign ie_rd = ie_q;
  assign irq   = irq_q;
`else
  assign ie_rd = 1'b0;
`endif

  always_comb begin
    RD = '0;
    case (A)
      FACT_A_N:      RD = DATA_W'(n_q);
      FACT_A_CTRL:   RD[CTRL_IE_BIT] = ie_rd;
      FACT_A_STATUS: begin
        RD[STAT_DONE_BIT] = done_q;
        RD[STAT_ERR_BIT]  = err_q;
        RD[STAT_BUSY_BIT] = !idle;
      end
      FACT_A_RESULT: RD = DATA_W'(result_q);
      default:       RD = '0;
    endcase
  end

  assign n_out  = n_q;
  assign go_out = go_q;

endmodule

// File: tb/tb_fact_mmio.sv
// Self-checking bench for fact_mmio; the accelerator is modelled by driving
// done_in/error_in/result_in directly. Expected results go through a queue.
module tb_fact_mmio;
  import fact_pkg::*;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [1:0]  A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [3:0]  n_out;
  logic        go_out;
  logic        done_in;
  logic        error_in;
  logic [31:0] result_in;
`ifdef FACT_IRQ_EN
  logic        irq;
`endif

  fact_mmio #(.DATA_W(32), .N_W(4), .RES_W(32)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .A(A), .WD(WD), .RD(RD),
    .n_out(n_out), .go_out(go_out), .done_in(done_in),
    .error_in(error_in), .result_in(result_in)
`ifdef FACT_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int go_count = 0;
  logic [31:0] exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (go_out === 1'b1) go_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fact(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  // All tasks start and end just after a falling edge; writes land on the next rise.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1; A = a; WD = d;
    @(negedge CLK);
    WE = 1'b0; WD = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  task automatic pulse_done(input logic [31:0] res);
    done_in = 1'b1; result_in = res;
    @(negedge CLK);
    done_in = 1'b0; result_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pop_and_check(input string name);
    logic [31:0] rd, e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty when result appeared", name);
    end else begin
      e = exp_q.pop_front();
      bus_read(FACT_A_RESULT, rd);
      if (rd !== e) begin
        n_bad++;
        $display("FAIL %s: RESULT got %0d want %0d", name, rd, e);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_cmp++;
      if (rd !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg%0d: got %0h want 0", a, rd);
      end
    end
    n_cmp++;
    if (go_out !== 1'b0 || n_out !== 4'd0) begin
      n_bad++; $display("FAIL reset_outs: go_out %b n_out %0d want 0 0", go_out, n_out);
    end
`ifdef FACT_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    int g0;
    g0 = go_count;
    bus_write(FACT_A_N, 32'd5);
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(5));
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (go_out !== 1'b1 || rd !== 32'd4) begin
      n_bad++; $display("FAIL basic_start: go_out %b status %0h want 1 4", go_out, rd);
    end
    idle(1);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (go_out !== 1'b0 || rd !== 32'd4 || n_out !== 4'd5) begin
      n_bad++; $display("FAIL basic_busy: go_out %b status %0h n_out %0d want 0 4 5", go_out, rd, n_out);
    end
    idle(8);
    pulse_done(32'd120);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL basic_done: status %0h want 1", rd); end
    pop_and_check("basic_result");
    idle(2);
    n_cmp++;
    if (go_count - g0 !== 1) begin
      n_bad++; $display("FAIL basic_go_width: go cycles %0d want 1", go_count - g0);
    end
  endtask

  task automatic test_error;
    logic [31:0] rd;
    bus_write(FACT_A_N, 32'd13);
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(13));
    idle(3);
    error_in = 1'b1;
    @(negedge CLK);
    error_in = 1'b0;
    idle(2);
    pulse_done(32'd1932053504);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd3) begin n_bad++; $display("FAIL error_status: status %0h want 3", rd); end
    pop_and_check("error_result");
  endtask

  task automatic test_busy_writes;
    logic [31:0] rd;
    int g0;
    g0 = go_count;
    bus_write(FACT_A_N, 32'd3);
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(3));
    idle(2);
    bus_write(FACT_A_N, 32'd7);
    bus_read(FACT_A_N, rd);
    n_cmp++;
    if (rd !== 32'd3 || n_out !== 4'd3) begin
      n_bad++; $display("FAIL busy_n_write: N %0d n_out %0d want 3 3", rd, n_out);
    end
    bus_write(FACT_A_CTRL, 32'd1);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (go_out !== 1'b0 || rd !== 32'd4) begin
      n_bad++; $display("FAIL busy_go_write: go_out %b status %0h want 0 4", go_out, rd);
    end
    pulse_done(32'd6);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL busy_done: status %0h want 1", rd); end
    pop_and_check("busy_result");
    idle(1);
    n_cmp++;
    if (go_count - g0 !== 1) begin
      n_bad++; $display("FAIL busy_go_count: go cycles %0d want 1", go_count - g0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus_write(FACT_A_N, 32'd4);
    bus_write(FACT_A_CTRL, 32'd1);
    idle(2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_cmp++;
      if (rd !== 32'd0) begin
        n_bad++; $display("FAIL rst_mid_reg%0d: got %0h want 0", a, rd);
      end
    end
    n_cmp++;
    if (go_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_go: got %b want 0", go_out); end
    pulse_done(32'd24);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL rst_mid_late_done: status %0h want 0", rd); end
    bus_read(FACT_A_RESULT, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL rst_mid_result: got %0d want 0", rd); end
  endtask

  task automatic test_clr_stray;
    logic [31:0] rd;
    bus_write(FACT_A_N, 32'd6);
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(6));
    idle(3);
    pulse_done(32'd720);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL clr_done: status %0h want 1", rd); end
    pop_and_check("clr_result");
    bus_write(FACT_A_CTRL, 32'd2);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL clr_status: status %0h want 0", rd); end
    bus_read(FACT_A_RESULT, rd);
    n_cmp++;
    if (rd !== 32'd720) begin n_bad++; $display("FAIL clr_keeps_result: got %0d want 720", rd); end
    error_in = 1'b1;
    pulse_done(32'd99);
    error_in = 1'b0;
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL stray_status: status %0h want 0", rd); end
    bus_read(FACT_A_RESULT, rd);
    n_cmp++;
    if (rd !== 32'd720) begin n_bad++; $display("FAIL stray_result: got %0d want 720", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    bus_write(FACT_A_N, 32'd2);
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(2));
    idle(2);
    pulse_done(32'd2);
    pop_and_check("b2b_first_result");
    bus_write(FACT_A_CTRL, 32'd3);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (go_out !== 1'b1 || rd !== 32'd4) begin
      n_bad++; $display("FAIL b2b_restart: go_out %b status %0h want 1 4", go_out, rd);
    end
    bus_read(FACT_A_RESULT, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL b2b_result_cleared: got %0d want 0", rd); end
    exp_q.push_back(fact(2));
    idle(2);
    pulse_done(32'd2);
    bus_read(FACT_A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL b2b_done: status %0h want 1", rd); end
    pop_and_check("b2b_second_result");
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    bus_write(FACT_A_CTRL, 32'd4);
    bus_read(FACT_A_CTRL, rd);
`ifdef FACT_IRQ_EN
    n_cmp++;
    if (rd !== 32'd4) begin n_bad++; $display("FAIL irq_ie_read: got %0h want 4", rd); end
    bus_write(FACT_A_N, 32'd5);
    bus_write(FACT_A_CTRL, 32'd5);
    exp_q.push_back(fact(5));
    idle(2);
    pulse_done(32'd120);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq); end
    pop_and_check("irq_result");
    idle(1);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus_write(FACT_A_CTRL, 32'd6);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clr: got %b want 0", irq); end
    bus_write(FACT_A_CTRL, 32'd1);
    exp_q.push_back(fact(5));
    idle(2);
    pulse_done(32'd120);
    pop_and_check("irq_off_result");
    idle(1);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_ie0: got %b want 0", irq); end
`else
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL ie_absent_read: got %0h want 0", rd); end
`endif
  endtask

  initial begin
    RST = 1'b1; WE = 1'b0; A = '0; WD = '0;
    done_in = 1'b0; error_in = 1'b0; result_in = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_basic();
    test_error();
    test_busy_writes();
    test_reset_mid();
    test_clr_stray();
    test_back_to_back();
    test_irq();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
